// File: rtl/i2c_transaction_sequencer.sv
// rtl/i2c_transaction_sequencer.sv - register read/write command sequencer for an i2c master controller
module i2c_transaction_sequencer #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_start,
   input  logic       i_rw,
   input  logic [6:0] i_dev_addr,
   input  logic [7:0] i_reg_addr,
   input  logic [7:0] i_wdata,
   output logic       o_busy,
   output logic       o_done,
   output logic [7:0] o_rdata,
   output logic       o_nack_err,
   output logic       o_timeout_err,
   output logic [2:0] o_cmd,
   output logic [7:0] o_din,
   output logic       o_wr_i2c,
   input  logic       i_ctrl_ready,
   input  logic [7:0] i_ctrl_dout,
   input  logic       i_ctrl_ack
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_DONE} state_t;

   localparam logic [2:0]  CMD_START   = 3'b001;
   localparam logic [2:0]  CMD_WR      = 3'b010;
   localparam logic [2:0]  CMD_RD      = 3'b011;
   localparam logic [2:0]  CMD_STOP    = 3'b100;
   localparam logic [2:0]  CMD_RESTART = 3'b101;
   localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [2:0]  step_q, step_d;
   logic        rw_q, rw_d;
   logic [6:0]  dev_q, dev_d;
   logic [7:0]  reg_q, reg_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [15:0] cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        nack_q, nack_d;
   logic        tmo_q, tmo_d;
   logic [2:0]  cmd_q, cmd_d;
   logic [7:0]  din_q, din_d;
   logic        wr_q, wr_d;

   logic [2:0]  step_cmd;
   logic [7:0]  step_din;
   logic [2:0]  last_step;

   // Map the position in the command list to a controller command and data byte
   always_comb begin
      step_cmd  = CMD_STOP;
      step_din  = 8'h00;
      last_step = rw_q ? 3'd6 : 3'd4;
      if (step_q != last_step) begin
         case (step_q)
            3'd0: step_cmd = CMD_START;
            3'd1: begin step_cmd = CMD_WR; step_din = {dev_q, 1'b0}; end
            3'd2: begin step_cmd = CMD_WR; step_din = reg_q; end
            3'd3: begin
               if (rw_q) begin
                  step_cmd = CMD_RESTART;
               end else begin
                  step_cmd = CMD_WR;
                  step_din = wdata_q;
               end
            end
            3'd4: begin step_cmd = CMD_WR; step_din = {dev_q, 1'b1}; end
            3'd5: step_cmd = CMD_RD;
            default: step_cmd = CMD_STOP;
         endcase
      end
   end

   // Next-state and output logic; a NACK jumps straight to the STOP slot
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      rw_d    = rw_q;
      dev_d   = dev_q;
      reg_d   = reg_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      rdata_d = rdata_q;
      nack_d  = nack_q;
      tmo_d   = tmo_q;
      cmd_d   = cmd_q;
      din_d   = din_q;
      wr_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               rw_d    = i_rw;
               dev_d   = i_dev_addr;
               reg_d   = i_reg_addr;
               wdata_d = i_wdata;
               step_d  = 3'd0;
               busy_d  = 1'b1;
               nack_d  = 1'b0;
               tmo_d   = 1'b0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (i_ctrl_ready) begin
               cmd_d   = step_cmd;
               din_d   = step_din;
               wr_d    = 1'b1;
               cnt_d   = 16'd0;
               state_d = S_WAIT_LO;
            end
         end
         S_WAIT_LO, S_WAIT_HI: begin
            if (cnt_q == TMO_LAST) begin
               // Abandon the transaction; the controller owns the bus state
               tmo_d   = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 16'd1;
               if (state_q == S_WAIT_LO) begin
                  if (!i_ctrl_ready) state_d = S_WAIT_HI;
               end else if (i_ctrl_ready) begin
                  if (cmd_q == CMD_STOP) begin
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = S_DONE;
                  end else begin
                     state_d = S_ISSUE;
                     step_d  = step_q + 3'd1;
                     if (cmd_q == CMD_WR && i_ctrl_ack) begin
                        nack_d = 1'b1;
                        step_d = last_step;
                     end
                     if (cmd_q == CMD_RD) rdata_d = i_ctrl_dout;
                  end
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= S_IDLE;
         step_q  <= 3'd0;
         rw_q    <= 1'b0;
         dev_q   <= 7'd0;
         reg_q   <= 8'd0;
         wdata_q <= 8'd0;
         cnt_q   <= 16'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rdata_q <= 8'd0;
         nack_q  <= 1'b0;
         tmo_q   <= 1'b0;
         cmd_q   <= 3'd0;
         din_q   <= 8'd0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         rw_q    <= rw_d;
         dev_q   <= dev_d;
         reg_q   <= reg_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
         nack_q  <= nack_d;
         tmo_q   <= tmo_d;
         cmd_q   <= cmd_d;
         din_q   <= din_d;
         wr_q    <= wr_d;
      end
   end

   assign o_busy        = busy_q;
   assign o_done        = done_q;
   assign o_rdata       = rdata_q;
   assign o_nack_err    = nack_q;
   assign o_timeout_err = tmo_q;
   assign o_cmd         = cmd_q;
   assign o_din         = din_q;
   assign o_wr_i2c      = wr_q;

endmodule

// File: tb/tb_i2c_transaction_sequencer.sv
// tb/tb_i2c_transaction_sequencer.sv - scoreboard bench for the i2c transaction sequencer
`timescale 1ns/1ps
module tb_i2c_transaction_sequencer;

   logic       i_clk = 1'b0;
   logic       i_reset_n, i_start, i_rw;
   logic [6:0] i_dev_addr;
   logic [7:0] i_reg_addr, i_wdata;
   logic       o_busy, o_done, o_nack_err, o_timeout_err, o_wr_i2c;
   logic [7:0] o_rdata, o_din;
   logic [2:0] o_cmd;
   logic       i_ctrl_ready, i_ctrl_ack;
   logic [7:0] i_ctrl_dout;

   always #5 i_clk = ~i_clk;

   i2c_transaction_sequencer #(.TIMEOUT_CYCLES(16)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_rw(i_rw),
      .i_dev_addr(i_dev_addr), .i_reg_addr(i_reg_addr), .i_wdata(i_wdata),
      .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata), .o_nack_err(o_nack_err),
      .o_timeout_err(o_timeout_err), .o_cmd(o_cmd), .o_din(o_din), .o_wr_i2c(o_wr_i2c),
      .i_ctrl_ready(i_ctrl_ready), .i_ctrl_dout(i_ctrl_dout), .i_ctrl_ack(i_ctrl_ack)
   );

   typedef struct {
      bit         is_done;
      logic [2:0] cmd;
      logic [7:0] din;
      logic [7:0] rdata;
      logic       nack;
      logic       tmo;
      int         lat;
   } exp_t;

   exp_t  exp_q[$];
   string snap_q[$];

   int n_cmp = 0, n_bad = 0;
   int seen_wr = 0, seen_done = 0, cyc = 0, last_wr_cyc = 0;
   bit end_req = 0, end_ack = 0;

   int         model_wr = 0;
   int         nack_at = -1, hang_at = -1;
   logic [7:0] rd_byte = 8'h00;

   always @(posedge i_clk) cyc++;

   // Controller model: ready drops after each strobe and returns three cycles later
   initial begin
      i_ctrl_ready = 1'b1;
      i_ctrl_ack   = 1'b0;
      i_ctrl_dout  = 8'h00;
      forever begin
         @(negedge i_clk);
         if (o_wr_i2c) begin
            model_wr++;
            i_ctrl_ready = 1'b0;
            if (model_wr == hang_at) begin
               wait (hang_at < 0);
            end else begin
               repeat (3) @(negedge i_clk);
            end
            i_ctrl_ack   = (model_wr == nack_at);
            i_ctrl_dout  = rd_byte;
            i_ctrl_ready = 1'b1;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", nm, got, want);
      end
   endtask

   task automatic flag_fail(input string nm, input logic [31:0] got);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got event with value %0h, want no event", nm, got);
   endtask

   // Monitor: pops expectations whenever the DUT strobes a command or completes
   always @(negedge i_clk) begin
      exp_t  e;
      string nm;
      if (snap_q.size() != 0) begin
         nm = snap_q.pop_front();
         chk(nm, {8'd0, o_busy, o_done, o_wr_i2c, o_nack_err, o_timeout_err, o_cmd, o_din, o_rdata}, 32'd0);
      end
      if (o_wr_i2c) begin
         seen_wr++;
         last_wr_cyc = cyc;
         if (exp_q.size() == 0 || exp_q[0].is_done) begin
            flag_fail("unexpected_cmd", {21'd0, o_cmd, o_din});
         end else begin
            e = exp_q.pop_front();
            chk("cmd", o_cmd, e.cmd);
            chk("din", o_din, e.din);
            chk("busy_at_cmd", o_busy, 1);
         end
      end
      if (o_done) begin
         seen_done++;
         if (exp_q.size() == 0 || !exp_q[0].is_done) begin
            flag_fail("unexpected_done", {29'd0, o_nack_err, o_timeout_err, o_done});
         end else begin
            e = exp_q.pop_front();
            chk("rdata", o_rdata, e.rdata);
            chk("nack_err", o_nack_err, e.nack);
            chk("timeout_err", o_timeout_err, e.tmo);
            chk("busy_at_done", o_busy, 0);
            if (e.lat >= 0) chk("done_latency", cyc - last_wr_cyc, e.lat);
         end
      end
      if (end_req && !end_ack) begin
         chk("leftover_expectations", exp_q.size(), 0);
         end_ack = 1;
      end
   end

   task automatic push_cmd(input logic [2:0] c, input logic [7:0] d);
      exp_t e;
      e.is_done = 0; e.cmd = c; e.din = d; e.rdata = 0; e.nack = 0; e.tmo = 0; e.lat = -1;
      exp_q.push_back(e);
   endtask

   task automatic push_done(input logic [7:0] rd, input logic nk, input logic tm, input int lat);
      exp_t e;
      e.is_done = 1; e.cmd = 0; e.din = 0; e.rdata = rd; e.nack = nk; e.tmo = tm; e.lat = lat;
      exp_q.push_back(e);
   endtask

   task automatic req(input logic rw, input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] wd);
      @(negedge i_clk);
      i_rw = rw; i_dev_addr = dev; i_reg_addr = ra; i_wdata = wd; i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int target = seen_done + 1;
      int budget = 400;
      while (seen_done < target && budget > 0) begin
         @(negedge i_clk);
         budget--;
      end
      if (seen_done < target) begin
         $display("FAIL %s: got no o_done within 400 cycles, want o_done", nm);
         $fatal(1, "aborting run");
      end
   endtask

   task automatic wait_wr(input int target);
      int budget = 400;
      while (seen_wr < target && budget > 0) begin
         @(negedge i_clk);
         budget--;
      end
      if (seen_wr < target) begin
         $display("FAIL wait_strobe: got %0d strobes, want %0d", seen_wr, target);
         $fatal(1, "aborting run");
      end
   endtask

   initial begin
      int base;
      i_reset_n = 1'b0; i_start = 1'b0; i_rw = 1'b0;
      i_dev_addr = 7'd0; i_reg_addr = 8'd0; i_wdata = 8'd0;
      @(posedge i_clk); #1;
      snap_q.push_back("reset_state");
      repeat (2) @(posedge i_clk);
      #1 i_reset_n = 1'b1;

      // register write, all bytes acknowledged
      push_cmd(3'b001, 8'h00); push_cmd(3'b010, 8'hA0); push_cmd(3'b010, 8'h12);
      push_cmd(3'b010, 8'hA5); push_cmd(3'b100, 8'h00);
      push_done(8'h00, 0, 0, -1);
      req(1'b0, 7'h50, 8'h12, 8'hA5);
      wait_done("write");

      // register read returning 0x3C
      rd_byte = 8'h3C;
      push_cmd(3'b001, 8'h00); push_cmd(3'b010, 8'hA0); push_cmd(3'b010, 8'h34);
      push_cmd(3'b101, 8'h00); push_cmd(3'b010, 8'hA1); push_cmd(3'b011, 8'h00);
      push_cmd(3'b100, 8'h00);
      push_done(8'h3C, 0, 0, -1);
      req(1'b1, 7'h50, 8'h34, 8'h00);
      wait_done("read");

      // address byte NACKed: straight to STOP, rdata untouched
      nack_at = model_wr + 2;
      push_cmd(3'b001, 8'h00); push_cmd(3'b010, 8'hA0); push_cmd(3'b100, 8'h00);
      push_done(8'h3C, 1, 0, -1);
      req(1'b0, 7'h50, 8'h77, 8'h99);
      wait_done("nack");
      nack_at = -1;

      // controller hangs after START: done 16 cycles after the strobe, nack flag cleared
      hang_at = model_wr + 1;
      push_cmd(3'b001, 8'h00);
      push_done(8'h3C, 0, 1, 16);
      req(1'b0, 7'h50, 8'h12, 8'hA5);
      wait_done("timeout");
      repeat (20) @(negedge i_clk);
      hang_at = -1;
      repeat (3) @(negedge i_clk);

      // read with an ignored start while busy, then reset after RESTART
      base = seen_wr;
      push_cmd(3'b001, 8'h00); push_cmd(3'b010, 8'h54); push_cmd(3'b010, 8'h05);
      push_cmd(3'b101, 8'h00);
      req(1'b1, 7'h2A, 8'h05, 8'h00);
      wait_wr(base + 1);
      @(negedge i_clk);
      i_rw = 1'b0; i_dev_addr = 7'h11; i_reg_addr = 8'hEE; i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      wait_wr(base + 4);
      repeat (2) @(posedge i_clk);
      #1 i_reset_n = 1'b0;
      snap_q.push_back("reset_mid_read");
      repeat (3) @(negedge i_clk);
      @(posedge i_clk); #1 i_reset_n = 1'b1;
      repeat (10) @(negedge i_clk);

      // fresh write after reset
      push_cmd(3'b001, 8'h00); push_cmd(3'b010, 8'h76); push_cmd(3'b010, 8'h40);
      push_cmd(3'b010, 8'h5A); push_cmd(3'b100, 8'h00);
      push_done(8'h00, 0, 0, -1);
      req(1'b0, 7'h3B, 8'h40, 8'h5A);
      wait_done("write_after_reset");

      repeat (5) @(negedge i_clk);
      end_req = 1;
      repeat (3) @(negedge i_clk);
      if (!end_ack) begin
         $display("FAIL end_handshake: got no monitor response, want response");
         $fatal(1, "aborting run");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/i2c_transaction_sequencer.md
Name: i2c_transaction_sequencer

Overview:
- Upstream command sequencer for i2c_master_controller.
- Accepts a single-byte register write or register read request, then issues the matching START/WR/RD/RESTART/STOP command stream to the controller over its i_cmd/i_din/i_wr_i2c/o_ready handshake.
- Collects the read byte and the per-byte ACK status, and reports completion or error to the host logic.

Parameters:
- TIMEOUT_CYCLES, 4096: maximum i_clk cycles spent waiting on one controller command before aborting. Allowed range 2..65535.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_start  in  1  request strobe; sampled only in IDLE
- i_rw  in  1  0 = register write, 1 = register read
- i_dev_addr  in  7  7-bit slave address
- i_reg_addr  in  8  register address
- i_wdata  in  8  write data
- o_busy  out  1  high from accepted i_start until the o_done cycle
- o_done  out  1  one-cycle completion pulse
- o_rdata  out  8  read result; valid from o_done, held until the next accepted read
- o_nack_err  out  1  set with o_done if any written byte was NACKed
- o_timeout_err  out  1  set with o_done if any command timed out
- o_cmd  out  3  to controller i_cmd: START 001, WR 010, RD 011, STOP 100, RESTART 101
- o_din  out  8  to controller i_din
- o_wr_i2c  out  1  to controller i_wr_i2c; one-cycle issue strobe
- i_ctrl_ready  in  1  from controller o_ready
- i_ctrl_dout  in  8  controller received byte; valid when ready rises after RD
- i_ctrl_ack  in  1  controller ACK bit of the last WR (0 = ACK, 1 = NACK); valid when ready rises

Behaviour:
- Reset (async, i_reset_n low) values:
  - FSM in IDLE.
  - o_busy, o_done, o_wr_i2c, o_nack_err, o_timeout_err = 0.
  - o_cmd = 000, o_din = 0, o_rdata = 0.
- Request capture:
  - On i_start = 1 in IDLE, latch i_rw, i_dev_addr, i_reg_addr and i_wdata.
  - o_busy rises the next cycle.
  - i_start while busy is ignored; no queueing.
- Write command list: START; WR {dev,0}; WR reg; WR wdata; STOP.
- Read command list: START; WR {dev,0}; WR reg; RESTART; WR {dev,1}; RD; STOP.
  - RD is the final byte, so the controller NACKs it.
- Per-command phases:
  - ISSUE: wait for i_ctrl_ready = 1. Then drive o_cmd/o_din and assert o_wr_i2c for exactly one cycle. o_din = 0 for START/RESTART/STOP/RD.
  - WAIT_LO: wait for i_ctrl_ready = 0.
  - WAIT_HI: wait for i_ctrl_ready = 1. On that cycle, capture i_ctrl_ack (after WR) or i_ctrl_dout into o_rdata (after RD), then advance to the next command's ISSUE.
  - o_cmd/o_din hold their values through WAIT_LO/WAIT_HI.
- Timeout:
  - A counter clears on each issue strobe and increments during WAIT_LO/WAIT_HI.
  - At TIMEOUT_CYCLES-1 the sequencer sets o_timeout_err and jumps to DONE. No STOP is issued; the bus is left to the controller.
- NACK handling:
  - If the captured ack = 1 after any WR, set o_nack_err, skip the remaining commands and issue STOP.
  - After the STOP completes, go to DONE. o_rdata is not updated.
- DONE:
  - o_done = 1 for one cycle; o_busy = 0 in the same cycle; return to IDLE.
  - Error flags are cleared on the next accepted i_start.
- Simultaneous i_start and o_done cycle: the start is ignored, because the FSM is not in IDLE.
- Reset mid-transaction: immediate return to reset values. No STOP is generated.
- Latency, ideal controller (ready low 1 cycle after issue, high N cycles later), per command: 1 issue + 1 + N cycles.

Test Plan:
- Write: dev 0x50, reg 0x12, data 0xA5, all ACK.
  - Required: cmd sequence 001, 010/din 0xA0, 010/0x12, 010/0xA5, 100.
  - One o_done pulse with both error flags 0; o_busy high throughout.
- Read: dev 0x50, reg 0x34, controller returns 0x3C.
  - Required: cmd sequence 001, 010/0xA0, 010/0x34, 101, 010/0xA1, 011, 100.
  - o_rdata = 0x3C at o_done.
- NACK on the address byte (ack = 1 after the first WR).
  - Required: next command is 100 (STOP), then o_done with o_nack_err = 1.
  - No reg or data WR is issued; o_rdata is unchanged.
- Timeout: TIMEOUT_CYCLES = 16, controller holds ready low after START.
  - Required: o_done with o_timeout_err = 1 exactly 16 cycles after the issue strobe; no further o_wr_i2c.
- i_start pulsed while busy, plus reset asserted mid-read after RESTART.
  - Required: the second i_start has no effect.
  - On reset, all outputs go to 0 asynchronously.
  - A new write after reset completes normally with fresh flags.
